// File: rtl/mmio_memory_bridge.sv
// mmio_memory_bridge: decodes core memory accesses to word RAM, LED/cycle/UART MMIO registers, or an unmapped hole.
module mmio_memory_bridge #(
  parameter int    RAM_WORDS    = 512,
  parameter string INIT_FILE    = "",
  parameter int    LED_WIDTH    = 8,
  parameter int    CLKS_PER_BIT = 868
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [31:0]          mem_addr,
  input  logic [31:0]          mem_wr_data,
  input  logic                 mem_wr_ena,
  output logic [31:0]          mem_rd_data,
  output logic [LED_WIDTH-1:0] leds,
  output logic                 uart_tx
);
  localparam int AW = $clog2(RAM_WORDS);
  localparam int BW = $clog2(CLKS_PER_BIT);
  typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;
  logic [31:0]   ram [RAM_WORDS];
  logic [63:0]   cycles;
  logic [31:0]   hi_shadow, rd_n;
  state_t        state, state_n;
  logic [BW-1:0] baud, baud_n;
  logic [2:0]    bit_cnt, bit_n;
  logic [7:0]    sh, sh_n;
  logic [1:0]    sel;
  logic          is_ram, is_mmio, uart_wr, busy, bit_end, tx_n, unused_bits;
  assign unused_bits = ^mem_addr[1:0];
  assign is_ram  = mem_addr[31:28] == 4'h0 && mem_addr[31:2] < 30'(RAM_WORDS);
  assign is_mmio = mem_addr[31:4] == 28'hF000000;
  assign sel     = mem_addr[3:2];
  assign busy    = state != IDLE;
  assign bit_end = baud == BW'(CLKS_PER_BIT - 1);
  assign uart_wr = mem_wr_ena && is_mmio && sel == 2'd3;
  always_ff @(posedge clk)
    if (mem_wr_ena && is_ram) ram[mem_addr[AW+1:2]] <= mem_wr_data;
  always_comb begin
    rd_n = is_ram ? ram[mem_addr[AW+1:2]] : '0;
    if (is_mmio) rd_n = sel == 2'd0 ? 32'(leds) : sel == 2'd1 ? cycles[31:0] :
                        sel == 2'd2 ? hi_shadow : {31'b0, busy};
  end
  always_comb begin
    state_n = state;
    baud_n  = busy && !bit_end ? baud + 1'b1 : '0;
    bit_n   = bit_cnt;
    sh_n    = sh;
    case (state)
      START:   if (bit_end) state_n = DATA;
      DATA:    if (bit_end) begin
        sh_n  = sh >> 1;
        bit_n = bit_cnt + 1'b1;
        if (bit_cnt == 3'd7) state_n = STOP;
      end
      STOP:    if (bit_end) state_n = IDLE;
      default: state_n = state;
    endcase
    if (uart_wr && (state == IDLE || (state == STOP && bit_end))) begin
      state_n = START;
      baud_n  = '0;
      bit_n   = '0;
      sh_n    = mem_wr_data[7:0];
    end
    tx_n = state_n == START ? 1'b0 : state_n == DATA ? sh_n[0] : 1'b1;
  end
  always_ff @(posedge clk or negedge rst)
    if (!rst) begin
      mem_rd_data <= '0;
      leds        <= '0;
      cycles      <= '0;
      hi_shadow   <= '0;
      state       <= IDLE;
      baud        <= '0;
      bit_cnt     <= '0;
      sh          <= '0;
      uart_tx     <= 1'b1;
    end else begin
      mem_rd_data <= rd_n;
      cycles      <= cycles + 64'd1;
      if (is_mmio && sel == 2'd1) hi_shadow <= cycles[63:32];
      if (mem_wr_ena && is_mmio && sel == 2'd0) leds <= mem_wr_data[LED_WIDTH-1:0];
      state       <= state_n;
      baud        <= baud_n;
      bit_cnt     <= bit_n;
      sh          <= sh_n;
      uart_tx     <= tx_n;
    end
endmodule

// File: tb/tb_mmio_memory_bridge.sv
// tb_mmio_memory_bridge: directed stimulus with a queue scoreboard checked by an independent monitor.
module tb_mmio_memory_bridge;
  logic        clk = 0, rst = 0, mem_wr_ena = 0, uart_tx;
  logic [31:0] mem_addr = 0, mem_wr_data = 0, mem_rd_data;
  logic [7:0]  leds;
  typedef struct {int kind; logic [31:0] v; string name;} exp_t;
  exp_t sb[$];
  int checks = 0, errors = 0;
  event async_chk;
  always #5 clk = ~clk;
  mmio_memory_bridge #(.RAM_WORDS(512), .LED_WIDTH(8), .CLKS_PER_BIT(4)) dut (
    .clk(clk), .rst(rst), .mem_addr(mem_addr), .mem_wr_data(mem_wr_data),
    .mem_wr_ena(mem_wr_ena), .mem_rd_data(mem_rd_data), .leds(leds), .uart_tx(uart_tx)
  );
  task automatic drain();
    while (sb.size() > 0) begin
      exp_t e;
      logic [31:0] a;
      e = sb.pop_front();
      a = e.kind == 0 ? mem_rd_data : e.kind == 1 ? {24'b0, leds} : {31'b0, uart_tx};
      checks++;
      if (a !== e.v) begin
        errors++;
        $display("FAIL %s: got %h expected %h", e.name, a, e.v);
      end
    end
  endtask
  always @(posedge clk) begin
    #1;
    drain();
  end
  always @(async_chk) drain();
  task automatic step(input logic [31:0] a, input logic [31:0] d, input logic we);
    @(negedge clk);
    mem_addr = a;
    mem_wr_data = d;
    mem_wr_ena = we;
  endtask
  task automatic want(input int kind, input logic [31:0] v, input string name);
    sb.push_back('{kind, v, name});
  endtask
  function automatic logic frame_bit(input logic [7:0] d, input int pos);
    return pos == 0 ? 1'b0 : pos == 9 ? 1'b1 : d[pos-1];
  endfunction
  initial begin
    step(0, 0, 0);
    want(0, 0, "rst_rd"); want(1, 0, "rst_leds"); want(2, 1, "rst_tx");
    @(negedge clk) rst = 1;
    step(32'h0, 32'h11111111, 1);
    step(32'h10, 32'hDEADBEEF, 1);
    step(32'h10, 0, 0);          want(0, 32'hDEADBEEF, "ram_rd");
    step(32'h13, 0, 0);          want(0, 32'hDEADBEEF, "ram_rd_unaligned");
    step(32'h20, 32'h77, 1);
    step(32'h20, 32'h1, 1);      want(0, 32'h77, "ram_rbw_old");
    step(32'h20, 0, 0);          want(0, 32'h1, "ram_rbw_new");
    step(32'h00010000, 32'hBAD, 1); want(0, 0, "hole_wr_rd");
    step(32'h00010000, 0, 0);    want(0, 0, "hole_rd");
    step(32'h7FC, 32'hCAFEF00D, 1);
    step(32'h800, 32'h12345678, 1); want(0, 0, "hole_past_ram");
    step(32'h7FC, 0, 0);         want(0, 32'hCAFEF00D, "ram_last_word");
    step(32'h0, 0, 0);           want(0, 32'h11111111, "ram_word0_intact");
    step(32'hF0000000, 32'h1A5, 1); want(1, 32'hA5, "leds_wr"); want(0, 0, "leds_rbw_old");
    step(32'hF0000000, 0, 0);    want(0, 32'hA5, "leds_rd");
    step(32'hF0000004, 0, 0);
    force dut.cycles = 64'h0000_0000_FFFF_FFFF;
    #1 release dut.cycles;
    want(0, 32'hFFFFFFFF, "cyc_lo");
    step(32'hF0000008, 0, 0);    want(0, 32'h0, "cyc_hi_shadow");
    step(32'hF0000004, 0, 0);    want(0, 32'h1, "cyc_lo2");
    step(32'hF0000008, 0, 0);    want(0, 32'h1, "cyc_hi2");
    for (int i = 0; i < 54; i++) begin
      step(32'hF000000C, i == 0 ? 32'h55 : i == 5 ? 32'hFF : 32'hA3, i == 0 || i == 5 || i == 40);
      want(2, {31'b0, i < 40 ? frame_bit(8'h55, i / 4) : frame_bit(8'hA3, (i - 40) / 4)}, "uart_tx_bit");
      want(0, i == 0 ? 32'h0 : 32'h1, "uart_busy");
    end
    @(negedge clk);
    #2 rst = 0;
    #1 want(0, 0, "async_rd"); want(1, 0, "async_leds"); want(2, 1, "async_tx");
    -> async_chk;
    repeat (2) @(negedge clk);
    rst = 1;
    step(32'hF000000C, 0, 0);    want(0, 0, "post_rst_busy"); want(2, 1, "post_rst_tx");
    step(32'h10, 0, 0);          want(0, 32'hDEADBEEF, "post_rst_ram10");
    step(32'h20, 0, 0);          want(0, 32'h1, "post_rst_ram20");
    step(32'h0, 0, 0);           want(0, 32'h11111111, "post_rst_ram0");
    step(32'h0, 0, 0);
    @(negedge clk);
    if (sb.size() != 0) begin
      errors++;
      $display("FAIL scoreboard_drain: got %0d pending expected 0", sb.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
